// File: rtl/xbar_sched_4x4.sv
// xbar_sched_4x4: buffered, arbitrated front end for a 4x4 crossbar.
// Each input holds one word in a single-entry slot tagged with a destination.
// Every output has its own round-robin arbiter and a registered valid/ready port.
// Optional build macro XBAR_STATS_EN adds an 8-bit saturating conflict counter.
module xbar_sched_4x4 #(
   parameter int DATA_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            in_valid,
   output logic [3:0]            in_ready,
   input  logic [4*DATA_W-1:0]   in_data,
   input  logic [7:0]            in_dst,
   output logic [3:0]            out_valid,
   input  logic [3:0]            out_ready,
   output logic [4*DATA_W-1:0]   out_data,
   output logic [7:0]            out_src
`ifdef XBAR_STATS_EN
   ,
   output logic [7:0]            conflict_cnt
`endif
);

   // Input slot state
   logic [3:0]        slot_full_r;
   logic [DATA_W-1:0] slot_data_r [4];
   logic [1:0]        slot_dst_r  [4];

   // Output port and arbiter state
   logic [3:0]          out_valid_r;
   logic [4*DATA_W-1:0] out_data_r;
   logic [7:0]          out_src_r;
   logic [1:0]          rr_r [4];

   // Arbitration results for the current cycle
   logic [3:0] free_s;
   logic [3:0] cand_s    [4];
   logic [3:0] win_vld_s;
   logic [1:0] win_idx_s [4];
   logic [3:0] fire_s;
   logic [3:0] grant_s;
   logic [1:0] scan_idx_s;

   // in_ready is a plain inversion of slot state, so it never depends on out_ready
   assign in_ready  = ~slot_full_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_src   = out_src_r;

   // Per-output candidate detection and round-robin winner selection
   always_comb begin
      free_s     = ~out_valid_r | out_ready;
      win_vld_s  = 4'b0000;
      fire_s     = 4'b0000;
      scan_idx_s = 2'd0;
      for (int j = 0; j < 4; j++) begin
         cand_s[j]    = 4'b0000;
         win_idx_s[j] = 2'd0;
         for (int i = 0; i < 4; i++) begin
            cand_s[j][i] = slot_full_r[i] & (slot_dst_r[i] == 2'(j));
         end
         // Scan upward from the pointer; the first hit wins
         for (int k = 0; k < 4; k++) begin
            scan_idx_s = rr_r[j] + 2'(k);
            if (!win_vld_s[j] && cand_s[j][scan_idx_s]) begin
               win_vld_s[j] = 1'b1;
               win_idx_s[j] = scan_idx_s;
            end else begin
               win_idx_s[j] = win_idx_s[j];
            end
         end
         fire_s[j] = free_s[j] & win_vld_s[j];
      end
   end

   // Map output grants back to the input slots they drain
   always_comb begin
      grant_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (fire_s[j] && (win_idx_s[j] == 2'(i))) begin
               grant_s[i] = 1'b1;
            end else begin
               grant_s[i] = grant_s[i];
            end
         end
      end
   end

   // Input slots: drain on grant, fill on handshake (never both, since in_ready=~full)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_full_r <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            slot_data_r[i] <= {DATA_W{1'b0}};
            slot_dst_r[i]  <= 2'd0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (grant_s[i]) begin
               slot_full_r[i] <= 1'b0;
            end else if (in_valid[i] && !slot_full_r[i]) begin
               slot_full_r[i] <= 1'b1;
               slot_data_r[i] <= in_data[i*DATA_W +: DATA_W];
               slot_dst_r[i]  <= in_dst[2*i +: 2];
            end else begin
               slot_full_r[i] <= slot_full_r[i];
            end
         end
      end
   end

   // Output registers and round-robin pointers; stalled outputs hold everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 4'b0000;
         out_data_r  <= {(4*DATA_W){1'b0}};
         out_src_r   <= 8'd0;
         for (int j = 0; j < 4; j++) begin
            rr_r[j] <= 2'd0;
         end
      end else begin
         for (int j = 0; j < 4; j++) begin
            if (fire_s[j]) begin
               out_valid_r[j]                  <= 1'b1;
               out_data_r[j*DATA_W +: DATA_W]  <= slot_data_r[win_idx_s[j]];
               out_src_r[2*j +: 2]             <= win_idx_s[j];
               rr_r[j]                         <= win_idx_s[j] + 2'd1;
            end else if (free_s[j]) begin
               out_valid_r[j] <= 1'b0;
            end else begin
               out_valid_r[j] <= out_valid_r[j];
            end
         end
      end
   end

`ifdef XBAR_STATS_EN
   logic       conflict_s;
   logic [7:0] conflict_cnt_r;

   assign conflict_cnt = conflict_cnt_r;

   // A conflict is a free output facing two or more candidates
   always_comb begin
      conflict_s = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if (free_s[j] && ((cand_s[j] & (cand_s[j] - 4'd1)) != 4'b0000)) begin
            conflict_s = 1'b1;
         end else begin
            conflict_s = conflict_s;
         end
      end
   end

   // Saturating conflict counter, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt_r <= 8'd0;
      end else if (conflict_s && (conflict_cnt_r != 8'hFF)) begin
         conflict_cnt_r <= conflict_cnt_r + 8'd1;
      end else begin
         conflict_cnt_r <= conflict_cnt_r;
      end
   end
`endif

endmodule

// File: tb/tb_xbar_sched_4x4.sv
// Directed testbench for xbar_sched_4x4 with per-lane expected-word queues.
module tb_xbar_sched_4x4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [15:0] in_data;
   logic [7:0]  in_dst;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [15:0] out_data;
   logic [7:0]  out_src;
`ifdef XBAR_STATS_EN
   logic [7:0]  conflict_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // expected words per output lane, {src, data}
   logic [5:0] q0[$];
   logic [5:0] q1[$];
   logic [5:0] q2[$];
   logic [5:0] q3[$];

   logic [5:0] mon_got;
   logic [5:0] mon_exp;
   logic       mon_have;

   xbar_sched_4x4 #(.DATA_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dst    (in_dst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src)
`ifdef XBAR_STATS_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int lane, input logic [3:0] d, input logic [1:0] s);
      case (lane)
         0: q0.push_back({s, d});
         1: q1.push_back({s, d});
         2: q2.push_back({s, d});
         default: q3.push_back({s, d});
      endcase
   endtask

   task automatic flush();
      q0.delete();
      q1.delete();
      q2.delete();
      q3.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a word leaves lane j at the next rising edge when valid & ready
   always @(negedge clk) begin
      if (rst_n) begin
         for (int j = 0; j < 4; j++) begin
            if (out_valid[j] && out_ready[j]) begin
               mon_got  = {out_src[2*j +: 2], out_data[4*j +: 4]};
               mon_have = 1'b1;
               mon_exp  = 6'd0;
               case (j)
                  0: if (q0.size() > 0) mon_exp = q0.pop_front(); else mon_have = 1'b0;
                  1: if (q1.size() > 0) mon_exp = q1.pop_front(); else mon_have = 1'b0;
                  2: if (q2.size() > 0) mon_exp = q2.pop_front(); else mon_have = 1'b0;
                  default: if (q3.size() > 0) mon_exp = q3.pop_front(); else mon_have = 1'b0;
               endcase
               if (mon_have) begin
                  check($sformatf("lane%0d word {src,data}", j), 32'(mon_got), 32'(mon_exp));
               end else begin
                  checks++;
                  errors++;
                  $display("FAIL lane%0d unexpected word: got src=%0d data=%0h expected none",
                           j, mon_got[5:4], mon_got[3:0]);
               end
            end
         end
      end
   end

   initial begin
      // 1. reset with random inputs
      rst_n     = 1'b0;
      out_ready = 4'hF;
      in_valid  = 4'($urandom());
      in_data   = 16'($urandom());
      in_dst    = 8'($urandom());
      for (int n = 0; n < 3; n++) begin
         tick();
         in_valid = 4'($urandom());
         in_data  = 16'($urandom());
         in_dst   = 8'($urandom());
      end
      check("reset out_valid", 32'(out_valid), 32'h0);
      check("reset in_ready", 32'(in_ready), 32'hF);
      check("reset out_data", 32'(out_data), 32'h0);
      check("reset out_src", 32'(out_src), 32'h0);
      in_valid = 4'b0000;
      rst_n    = 1'b1;

      // 2. single route: in0 data 5 -> out2
      in_valid = 4'b0001;
      in_data  = 16'h0005;
      in_dst   = 8'b00_00_00_10;
      push(2, 4'h5, 2'd0);
      tick();
      in_valid = 4'b0000;
      check("single accepted in_ready", 32'(in_ready), 32'hE);
      check("single no bypass out_valid", 32'(out_valid), 32'h0);
      tick();
      check("single out_valid", 32'(out_valid), 32'h4);
      check("single lane2 data", 32'(out_data[11:8]), 32'h5);
      check("single lane2 src", 32'(out_src[5:4]), 32'h0);
      tick();
      check("single drained out_valid", 32'(out_valid), 32'h0);

      // 3. permutation: dst 3,2,1,0 with data 1,3,5,7
      in_valid = 4'hF;
      in_data  = 16'h7531;
      in_dst   = 8'b00_01_10_11;
      push(3, 4'h1, 2'd0);
      push(2, 4'h3, 2'd1);
      push(1, 4'h5, 2'd2);
      push(0, 4'h7, 2'd3);
      tick();
      in_valid = 4'b0000;
      tick();
      check("perm out_valid", 32'(out_valid), 32'hF);
      check("perm out_data", 32'(out_data), 32'h1357);
      check("perm out_src", 32'(out_src), 32'h1B);
`ifdef XBAR_STATS_EN
      check("perm conflict_cnt", 32'(conflict_cnt), 32'h0);
`endif
      tick();
      check("perm drained out_valid", 32'(out_valid), 32'h0);

      // reset pulse so every pointer starts at 0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;

      // 4. contention: all inputs -> out1
      in_valid = 4'hF;
      in_data  = 16'hDCBA;
      in_dst   = 8'b01_01_01_01;
      push(1, 4'hA, 2'd0);
      push(1, 4'hB, 2'd1);
      push(1, 4'hC, 2'd2);
      push(1, 4'hD, 2'd3);
      tick();
      in_valid = 4'b0000;
      check("contend all slots full", 32'(in_ready), 32'h0);
      tick();
      check("contend first out_valid", 32'(out_valid), 32'h2);
      check("contend first src", 32'(out_src[3:2]), 32'h0);
      tick();
      tick();
      tick();
      check("contend last src", 32'(out_src[3:2]), 32'h3);
`ifdef XBAR_STATS_EN
      check("contend conflict_cnt", 32'(conflict_cnt), 32'h3);
`endif
      tick();
      check("contend drained out_valid", 32'(out_valid), 32'h0);
      check("contend drained in_ready", 32'(in_ready), 32'hF);

      // rr[1] is 0: in1,in2 -> order 1,2, leaving rr[1]=3
      in_valid = 4'b0110;
      in_data  = 16'h0960;
      in_dst   = 8'b01_01_01_01;
      push(1, 4'h6, 2'd1);
      push(1, 4'h9, 2'd2);
      tick();
      in_valid = 4'b0000;
      tick();
      tick();
      // rr[1] is 3: in0,in3 -> order 3 then wrap to 0
      in_valid = 4'b1001;
      in_data  = 16'hE002;
      push(1, 4'hE, 2'd3);
      push(1, 4'h2, 2'd0);
      tick();
      in_valid = 4'b0000;
      tick();
      check("wrap first src", 32'(out_src[3:2]), 32'h3);
      tick();
      check("wrap second src", 32'(out_src[3:2]), 32'h0);
      tick();

      // 5. backpressure on out0
      out_ready = 4'b1110;
      in_valid  = 4'b0100;
      in_data   = 16'h0A00;
      in_dst    = 8'b00_00_00_00;
      push(0, 4'hA, 2'd2);
      tick();
      in_valid = 4'b0000;
      tick();
      in_valid = 4'b0100;
      in_data  = 16'h0300;
      push(0, 4'h3, 2'd2);
      tick();
      in_valid = 4'b0000;
      check("bp second word held in slot", 32'(in_ready[2]), 32'h0);
      for (int n = 0; n < 3; n++) begin
         tick();
         check("bp hold valid", 32'(out_valid[0]), 32'h1);
         check("bp hold data", 32'(out_data[3:0]), 32'hA);
         check("bp hold src", 32'(out_src[1:0]), 32'h2);
      end
      out_ready = 4'hF;
      tick();
      check("bp reload valid", 32'(out_valid[0]), 32'h1);
      check("bp reload data", 32'(out_data[3:0]), 32'h3);
      check("bp slot freed", 32'(in_ready[2]), 32'h1);
      tick();
      check("bp drained valid", 32'(out_valid[0]), 32'h0);

      // 6. async reset in the middle of a contention burst (rr[1] is 1)
      in_valid = 4'hF;
      in_data  = 16'h4321;
      in_dst   = 8'b01_01_01_01;
      push(1, 4'h2, 2'd1);
      push(1, 4'h3, 2'd2);
      push(1, 4'h4, 2'd3);
      push(1, 4'h1, 2'd0);
      tick();
      in_valid = 4'b0000;
      tick();
      check("midrst pre out_valid", 32'(out_valid), 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst async out_valid", 32'(out_valid), 32'h0);
      check("midrst async in_ready", 32'(in_ready), 32'hF);
      flush();
      tick();
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         tick();
         check("midrst no stale word", 32'(out_valid), 32'h0);
      end
      // pointers are back at 0: in0 before in3
      in_valid = 4'b1001;
      in_data  = 16'h7008;
      in_dst   = 8'b01_01_01_01;
      push(1, 4'h8, 2'd0);
      push(1, 4'h7, 2'd3);
      tick();
      in_valid = 4'b0000;
      tick();
      check("post-reset rr src", 32'(out_src[3:2]), 32'h0);
      tick();
      tick();
      tick();

      check("lane0 queue drained", 32'(q0.size()), 32'h0);
      check("lane1 queue drained", 32'(q1.size()), 32'h0);
      check("lane2 queue drained", 32'(q2.size()), 32'h0);
      check("lane3 queue drained", 32'(q3.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
